// File: rtl/chip8_framebuffer.sv
// 64x32 monochrome CHIP-8 screen: CPU single-pixel read/write, clear sequencer, display row port.
// Latency: CPU read 1 cycle, display row read 1 cycle; a clear takes HEIGHT cycles.
// Backpressure: none; CPU writes are dropped while fb_busy is high, display requests are always served.
module chip8_framebuffer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32
) (
  input  logic                      cpu_clk,
  input  logic                      reset_n,
  input  logic [$clog2(WIDTH)-1:0]  fb_addr_x,
  input  logic [$clog2(HEIGHT)-1:0] fb_addr_y,
  input  logic                      fb_writedata,
  input  logic                      fb_WE,
  output logic                      fb_readdata,
  input  logic                      fbreset,
  output logic                      fb_busy,
  input  logic                      disp_req,
  input  logic [$clog2(HEIGHT)-1:0] disp_row,
  output logic [WIDTH-1:0]          disp_data,
  output logic                      disp_valid
);

  localparam int RW = $clog2(HEIGHT);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [WIDTH-1:0] fb_mem [HEIGHT];
  logic [0:0]       state;
  logic [RW-1:0]    clr_cnt;

  // Busy is simply "clear in progress"; it rises the edge after fbreset is sampled.
  assign fb_busy = (state == CLEAR);

  // Clear sequencer and pixel storage; a clear owns the array, so CPU writes are dropped meanwhile.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      for (int r = 0; r < HEIGHT; r++) begin
        fb_mem[r] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fbreset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (fb_WE) begin
            fb_mem[fb_addr_y][fb_addr_x] <= fb_writedata;
          end
        end
        default: begin
          fb_mem[clr_cnt] <= '0;
          if (fbreset) begin
            // Restart from row 0: a fresh full HEIGHT-cycle clear follows.
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ROW) begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // CPU read port: samples the array before this edge's write, forced to 0 while clearing.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_readdata <= 1'b0;
    end else begin
      fb_readdata <= (state == IDLE) ? fb_mem[fb_addr_y][fb_addr_x] : 1'b0;
    end
  end

  // Display row port: one row per request, data holds when no request is made.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      disp_valid <= disp_req;
      if (disp_req) begin
        disp_data <= fb_mem[disp_row];
      end
    end
  end

endmodule

// File: tb/tb_chip8_framebuffer.sv
module tb_chip8_framebuffer;

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic [5:0]  fb_addr_x;
  logic [4:0]  fb_addr_y;
  logic        fb_writedata;
  logic        fb_WE;
  logic        fb_readdata;
  logic        fbreset;
  logic        fb_busy;
  logic        disp_req;
  logic [4:0]  disp_row;
  logic [63:0] disp_data;
  logic        disp_valid;

  int err_cnt = 0;
  int chk_cnt = 0;
  int busy_len;

  always #5 cpu_clk = ~cpu_clk;

  chip8_framebuffer #(.WIDTH(64), .HEIGHT(32)) dut (
    .cpu_clk      (cpu_clk),
    .reset_n      (reset_n),
    .fb_addr_x    (fb_addr_x),
    .fb_addr_y    (fb_addr_y),
    .fb_writedata (fb_writedata),
    .fb_WE        (fb_WE),
    .fb_readdata  (fb_readdata),
    .fbreset      (fbreset),
    .fb_busy      (fb_busy),
    .disp_req     (disp_req),
    .disp_row     (disp_row),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input logic d);
    fb_addr_x = 6'(x); fb_addr_y = 5'(y); fb_writedata = d; fb_WE = 1'b1;
    tick();
    fb_WE = 1'b0;
  endtask

  task automatic rd(input string tag, input int x, input int y, input logic exp);
    fb_addr_x = 6'(x); fb_addr_y = 5'(y);
    tick();
    check(tag, 64'(fb_readdata), 64'(exp));
  endtask

  initial begin
    reset_n = 1'b0; fb_addr_x = '0; fb_addr_y = '0; fb_writedata = 1'b0; fb_WE = 1'b0;
    fbreset = 1'b0; disp_req = 1'b0; disp_row = '0;
    #12;
    check("rst_busy", 64'(fb_busy), 64'd0);
    check("rst_rd", 64'(fb_readdata), 64'd0);
    check("rst_dvalid", 64'(disp_valid), 64'd0);
    check("rst_ddata", disp_data, 64'd0);
    reset_n = 1'b1;
    tick();

    // Write then read back; neighbour stays 0.
    wr(3, 9, 1'b1);
    rd("rd_3_9", 3, 9, 1'b1);
    rd("rd_4_9", 4, 9, 1'b0);

    // Read-before-write at the same address in the same cycle.
    fb_addr_x = 6'd10; fb_addr_y = 5'd5; fb_writedata = 1'b1; fb_WE = 1'b1;
    tick();
    fb_WE = 1'b0;
    check("rbw_old", 64'(fb_readdata), 64'd0);
    tick();
    check("rbw_new", 64'(fb_readdata), 64'd1);

    // Clear timing, dropped writes and zero reads while busy.
    wr(0, 0, 1'b1);
    wr(63, 31, 1'b1);
    wr(20, 15, 1'b1);
    fbreset = 1'b1;
    tick();
    fbreset = 1'b0;
    busy_len = 0;
    while (fb_busy && busy_len < 100) begin
      fb_WE = 1'b0;
      if (busy_len == 1) begin fb_addr_x = 6'd63; fb_addr_y = 5'd31; end
      if (busy_len == 2) check("rd_busy", 64'(fb_readdata), 64'd0);
      if (busy_len == 30) begin fb_addr_x = 6'd5; fb_addr_y = 5'd5; fb_writedata = 1'b1; fb_WE = 1'b1; end
      tick();
      busy_len++;
    end
    fb_WE = 1'b0;
    check("clr_len", 64'(busy_len), 64'd32);
    rd("clr_0_0", 0, 0, 1'b0);
    rd("clr_63_31", 63, 31, 1'b0);
    rd("clr_20_15", 20, 15, 1'b0);
    rd("clr_drop_wr", 5, 5, 1'b0);

    // A second fbreset 10 cycles in restarts the full clear.
    fbreset = 1'b1;
    tick();
    fbreset = 1'b0;
    busy_len = 0;
    while (fb_busy && busy_len < 100) begin
      fbreset = (busy_len == 9);
      tick();
      busy_len++;
    end
    fbreset = 1'b0;
    check("restart_len", 64'(busy_len), 64'd42);

    // Display port.
    for (int x = 3; x <= 10; x++) wr(x, 9, 1'b1);
    disp_req = 1'b1; disp_row = 5'd9;
    tick();
    disp_req = 1'b0;
    check("disp_valid", 64'(disp_valid), 64'd1);
    check("disp_row9", disp_data, 64'h0000_0000_0000_07F8);
    tick();
    check("disp_idle_vld", 64'(disp_valid), 64'd0);
    check("disp_hold", disp_data, 64'h0000_0000_0000_07F8);
    // Back-to-back rows, with a same-cycle write to the requested row.
    disp_req = 1'b1; disp_row = 5'd9;
    fb_addr_x = 6'd0; fb_addr_y = 5'd9; fb_writedata = 1'b1; fb_WE = 1'b1;
    tick();
    fb_WE = 1'b0;
    check("disp_prewrite", disp_data, 64'h0000_0000_0000_07F8);
    disp_row = 5'd0;
    tick();
    check("b2b_vld", 64'(disp_valid), 64'd1);
    check("b2b_row0", disp_data, 64'd0);
    disp_row = 5'd9;
    tick();
    disp_req = 1'b0;
    check("disp_postwrite", disp_data, 64'h0000_0000_0000_07F9);

    // Async reset mid-clear.
    fb_addr_x = 6'd0; fb_addr_y = 5'd9; fbreset = 1'b1; disp_req = 1'b1; disp_row = 5'd9;
    tick();
    fbreset = 1'b0; disp_req = 1'b0;
    check("pre_rst_busy", 64'(fb_busy), 64'd1);
    check("pre_rst_rd", 64'(fb_readdata), 64'd1);
    check("pre_rst_vld", 64'(disp_valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(fb_busy), 64'd0);
    check("arst_rd", 64'(fb_readdata), 64'd0);
    check("arst_vld", 64'(disp_valid), 64'd0);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    tick();
    for (int r = 0; r < 32; r++) begin
      disp_req = 1'b1; disp_row = 5'(r);
      tick();
      check($sformatf("arst_row%0d", r), disp_data, 64'd0);
    end
    disp_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
